// File: rtl/vend_sequencer.sv
// Vending transaction sequencer: item select, coin collection with credit ceiling,
// dispense handshake, nickel change payout and customer refund.
module vend_sequencer #(
    parameter int PRICE0      = 15,
    parameter int PRICE1      = 20,
    parameter int PRICE2      = 25,
    parameter int PRICE3      = 30,
    parameter int MAX_CREDIT  = 50,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] item_number,
    input  logic       select,
    input  logic       nickel_in,
    input  logic       dime_in,
    input  logic       cancel,
    input  logic       disp_ack,
    input  logic       coin_ack,
    output logic       disp_req,
    output logic       coin_req,
    output logic       coin_reject,
    output logic       vend_done,
    output logic       busy,
    output logic [5:0] credit,
    output logic [2:0] state_dbg
);

    // Handshakes: disp_req/coin_req are held high until the matching ack is
    // sampled high on a rising edge; that edge completes the transfer and acks
    // seen while the request is low are ignored.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_DISPENSE = 3'd2,
        S_CHANGE   = 3'd3,
        S_REFUND   = 3'd4
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic [5:0]    price;
    logic [5:0]    item_price;
    logic [6:0]    coin_sum;
    logic [6:0]    credit_sum;
    logic [5:0]    credit_nxt;
    logic          any_coin;
    logic          fits;
    logic          credited;
    logic          timed_out;

    assign state_dbg = state;

    always_comb begin
        coin_sum   = (nickel_in ? 7'd5 : 7'd0) + (dime_in ? 7'd10 : 7'd0);
        credit_sum = {1'b0, credit} + coin_sum;
        any_coin   = nickel_in | dime_in;
        fits       = credit_sum <= 7'(MAX_CREDIT);
        credited   = any_coin && fits;
        credit_nxt = credited ? credit_sum[5:0] : credit;
        timed_out  = !credited && (timer == TW'(TIMEOUT_CYC - 1));
        case (item_number)
            2'b00:   item_price = 6'(PRICE0);
            2'b01:   item_price = 6'(PRICE1);
            2'b10:   item_price = 6'(PRICE2);
            default: item_price = 6'(PRICE3);
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            price       <= 6'(PRICE0);
            credit      <= '0;
            disp_req    <= 1'b0;
            coin_req    <= 1'b0;
            coin_reject <= 1'b0;
            vend_done   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            vend_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    coin_reject <= any_coin;
                    if (select) begin
                        price <= item_price;
                        timer <= '0;
                        busy  <= 1'b1;
                        state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    // A cycle's coins are credited or rejected as a whole.
                    coin_reject <= any_coin && !fits;
                    credit      <= credit_nxt;
                    timer       <= credited ? '0 : timer + 1'b1;
                    if (cancel || timed_out) begin
                        if (credit_nxt == 6'd0) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            coin_req <= 1'b1;
                            state    <= S_REFUND;
                        end
                    end else if (credit >= price) begin
                        disp_req <= 1'b1;
                        state    <= S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    coin_reject <= any_coin;
                    if (disp_ack) begin
                        disp_req <= 1'b0;
                        credit   <= credit - price;
                        if (credit != price) begin
                            coin_req <= 1'b1;
                            state    <= S_CHANGE;
                        end else begin
                            vend_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_CHANGE, S_REFUND: begin
                    coin_reject <= any_coin;
                    if (coin_req && coin_ack) begin
                        credit <= credit - 6'd5;
                        if (credit == 6'd5) begin
                            coin_req  <= 1'b0;
                            busy      <= 1'b0;
                            vend_done <= (state == S_CHANGE);
                            state     <= S_IDLE;
                        end
                    end else if (credit == 6'd0) begin
                        coin_req <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: vend with and without change, refund,
// credit ceiling rejection, timeout refund and asynchronous reset mid-dispense.
module tb_vend_sequencer;

    localparam int TO = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] item_number = 2'b00;
    logic       select = 1'b0, nickel_in = 1'b0, dime_in = 1'b0, cancel = 1'b0;
    logic       disp_ack = 1'b0, coin_ack = 1'b0;
    logic       disp_req, coin_req, coin_reject, vend_done, busy;
    logic [5:0] credit;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int vend_cnt = 0, hs_cnt = 0, creq_cnt = 0;
    int v0, h0, c0;

    vend_sequencer #(.TIMEOUT_CYC(TO)) u_dut (
        .clock(clock), .reset(reset), .item_number(item_number), .select(select),
        .nickel_in(nickel_in), .dime_in(dime_in), .cancel(cancel),
        .disp_ack(disp_ack), .coin_ack(coin_ack), .disp_req(disp_req),
        .coin_req(coin_req), .coin_reject(coin_reject), .vend_done(vend_done),
        .busy(busy), .credit(credit), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // Mid-cycle monitors for pulses and completed payout handshakes.
    always @(negedge clock) begin
        if (vend_done) vend_cnt++;
        if (coin_req && coin_ack) hs_cnt++;
        if (coin_req) creq_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [1:0] item);
        item_number = item;
        select = 1'b1;
        tick();
        select = 1'b0;
        check_eq("enter_collect", state_dbg, 3'd1);
    endtask

    initial begin
        #12;
        @(negedge clock);
        reset = 1'b1;
        tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_credit", credit, 0);
        check_eq("rst_disp_req", disp_req, 0);
        check_eq("rst_coin_req", coin_req, 0);
        check_eq("rst_state", state_dbg, 3'd0);

        // coin in IDLE is rejected
        nickel_in = 1'b1;
        tick();
        nickel_in = 1'b0;
        check_eq("idle_reject", coin_reject, 1);
        check_eq("idle_credit", credit, 0);
        tick();
        check_eq("idle_reject_pulse", coin_reject, 0);

        // exact-price vend, three nickels for item 0
        c0 = creq_cnt;
        start(2'b00);
        nickel_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("s1_credit", credit, 5 * (i + 1));
        end
        nickel_in = 1'b0;
        check_eq("s1_still_collect", state_dbg, 3'd1);
        tick();
        check_eq("s1_dispense", state_dbg, 3'd2);
        check_eq("s1_disp_req", disp_req, 1);
        tick();
        check_eq("s1_disp_hold", disp_req, 1);
        v0 = vend_cnt;
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        check_eq("s1_disp_drop", disp_req, 0);
        check_eq("s1_credit0", credit, 0);
        check_eq("s1_vend_done", vend_done, 1);
        check_eq("s1_idle", state_dbg, 3'd0);
        tick();
        check_eq("s1_vend_pulse", vend_done, 0);
        check_eq("s1_vend_cnt", vend_cnt - v0, 1);
        check_eq("s1_no_coin_req", creq_cnt - c0, 0);

        // item 2 with three dimes, one nickel of change
        start(2'b10);
        dime_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("s2_credit", credit, 10 * (i + 1));
        end
        dime_in = 1'b0;
        tick();
        check_eq("s2_dispense", state_dbg, 3'd2);
        check_eq("s2_credit30", credit, 30);
        v0 = vend_cnt;
        h0 = hs_cnt;
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        check_eq("s2_change_credit", credit, 5);
        check_eq("s2_change_state", state_dbg, 3'd3);
        check_eq("s2_coin_req", coin_req, 1);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        check_eq("s2_credit0", credit, 0);
        check_eq("s2_coin_req_drop", coin_req, 0);
        check_eq("s2_vend_done", vend_done, 1);
        tick();
        check_eq("s2_hs", hs_cnt - h0, 1);
        check_eq("s2_vend_cnt", vend_cnt - v0, 1);

        // cancel with delayed coin_ack
        start(2'b01);
        dime_in = 1'b1;
        tick();
        dime_in = 1'b0;
        check_eq("s3_credit10", credit, 10);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check_eq("s3_refund", state_dbg, 3'd4);
        check_eq("s3_coin_req", coin_req, 1);
        v0 = vend_cnt;
        h0 = hs_cnt;
        for (int k = 0; k < 2; k++) begin
            repeat (3) tick();
            check_eq("s3_credit_hold", credit, 10 - 5 * k);
            coin_ack = 1'b1;
            tick();
            coin_ack = 1'b0;
            check_eq("s3_credit_dec", credit, 5 - 5 * k);
        end
        check_eq("s3_coin_req_drop", coin_req, 0);
        check_eq("s3_idle", state_dbg, 3'd0);
        tick();
        check_eq("s3_no_vend", vend_cnt - v0, 0);
        check_eq("s3_hs", hs_cnt - h0, 2);

        // ceiling rejection on the transition cycle, then reject in DISPENSE
        start(2'b11);
        nickel_in = 1'b1; tick(); nickel_in = 1'b0;
        dime_in = 1'b1; tick(); tick(); dime_in = 1'b0;
        check_eq("s4_credit25", credit, 25);
        nickel_in = 1'b1; dime_in = 1'b1;
        tick();
        check_eq("s4_credit40", credit, 40);
        check_eq("s4_collect", state_dbg, 3'd1);
        tick();
        nickel_in = 1'b0; dime_in = 1'b0;
        check_eq("s4_ovf_reject", coin_reject, 1);
        check_eq("s4_ovf_credit", credit, 40);
        check_eq("s4_dispense", state_dbg, 3'd2);
        nickel_in = 1'b1;
        tick();
        nickel_in = 1'b0;
        check_eq("s4_disp_reject", coin_reject, 1);
        check_eq("s4_disp_credit", credit, 40);
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        check_eq("s4_change10", credit, 10);
        coin_ack = 1'b1;
        tick();
        check_eq("s4_change5", credit, 5);
        tick();
        coin_ack = 1'b0;
        check_eq("s4_done", vend_done, 1);
        check_eq("s4_idle", state_dbg, 3'd0);

        // credit reaches the 50 ceiling, change 20 paid as four nickels
        start(2'b11);
        dime_in = 1'b1; tick(); tick();
        nickel_in = 1'b1; tick();
        check_eq("s5_credit35", credit, 35);
        tick();
        nickel_in = 1'b0; dime_in = 1'b0;
        check_eq("s5_credit50", credit, 50);
        check_eq("s5_no_reject", coin_reject, 0);
        check_eq("s5_dispense", state_dbg, 3'd2);
        h0 = hs_cnt;
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        check_eq("s5_change20", credit, 20);
        coin_ack = 1'b1;
        repeat (4) tick();
        coin_ack = 1'b0;
        check_eq("s5_credit0", credit, 0);
        check_eq("s5_vend_done", vend_done, 1);
        tick();
        check_eq("s5_hs", hs_cnt - h0, 4);

        // idle timeout refunds the single nickel
        start(2'b00);
        nickel_in = 1'b1;
        tick();
        nickel_in = 1'b0;
        repeat (TO - 1) tick();
        check_eq("s6_before_to", state_dbg, 3'd1);
        tick();
        check_eq("s6_refund", state_dbg, 3'd4);
        check_eq("s6_coin_req", coin_req, 1);
        check_eq("s6_credit5", credit, 5);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        check_eq("s6_credit0", credit, 0);
        check_eq("s6_idle", state_dbg, 3'd0);

        // asynchronous reset while dispensing
        start(2'b01);
        dime_in = 1'b1; tick(); tick(); dime_in = 1'b0;
        tick();
        check_eq("s7_disp_req", disp_req, 1);
        #2 reset = 1'b0;
        #1;
        check_eq("s7_rst_disp_req", disp_req, 0);
        check_eq("s7_rst_busy", busy, 0);
        check_eq("s7_rst_credit", credit, 0);
        check_eq("s7_rst_state", state_dbg, 3'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check_eq("s7_post_idle", state_dbg, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
